// File: rtl/mac_layer_sequencer_if.sv
// Bundles the run handshake and the memory/MAC control bus of the layer sequencer.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface mac_layer_sequencer_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();
  logic          start;
  logic [DW-1:0] instr_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] instr_addr;
  logic [AW-1:0] neuro_rd_addr;
  logic [AW-1:0] weight_rd_addr;
  logic          mac_en;
  logic          mac_first;
  logic          neuro_wr_en;
  logic [AW-1:0] neuro_wr_addr;

  modport master (
    input  start,
    input  instr_data,
    output busy,
    output done,
    output instr_addr,
    output neuro_rd_addr,
    output weight_rd_addr,
    output mac_en,
    output mac_first,
    output neuro_wr_en,
    output neuro_wr_addr
  );

  modport slave (
    output start,
    output instr_data,
    input  busy,
    input  done,
    input  instr_addr,
    input  neuro_rd_addr,
    input  weight_rd_addr,
    input  mac_en,
    input  mac_first,
    input  neuro_wr_en,
    input  neuro_wr_addr
  );
endinterface

// File: rtl/mac_layer_sequencer.sv
// Walks the layer-width table and drives neuron RAM, weight ROM and MAC controls
// for a whole feed-forward run. Terms are issued one per cycle; the MAC controls
// and write-backs travel through delay lines matching the memory/MAC latency.
module mac_layer_sequencer #(
  parameter int AW  = 8,
  parameter int DW  = 8,
  parameter int LAT = 2
) (
  input logic                   clk,
  input logic                   reset,
  mac_layer_sequencer_if.master bus
);

  localparam int DCW = $clog2(LAT + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state_reg, state_next;
  logic [AW-1:0]  ip_reg, ip_next;
  logic [DW-1:0]  nprev_reg, nprev_next;
  logic [DW-1:0]  ncur_reg, ncur_next;
  logic [DW-1:0]  in_cnt_reg, in_cnt_next;
  logic [DW-1:0]  out_cnt_reg, out_cnt_next;
  logic [AW-1:0]  rd_base_reg, rd_base_next;
  logic [AW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]  w_ptr_reg, w_ptr_next;
  logic [DCW-1:0] drain_cnt_reg, drain_cnt_next;
  logic           last_layer_reg, last_layer_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;
  logic [AW-1:0]  rd_addr_reg, rd_addr_next;
  logic [AW-1:0]  w_addr_reg, w_addr_next;

  // Per-term information entering the delay lines this cycle.
  logic           iss_valid;
  logic           iss_first;
  logic           iss_last;
  logic [AW-1:0]  iss_waddr;

  // Delay lines: stage k holds what becomes visible k cycles after the issue stage.
  logic           en_pipe_reg    [0:LAT];
  logic           first_pipe_reg [0:LAT];
  logic           wr_pipe_reg    [0:LAT+1];
  logic [AW-1:0]  wa_pipe_reg    [0:LAT+1];

  logic term_last;
  logic neuron_last;

  assign term_last   = (in_cnt_reg == nprev_reg - DW'(1));
  assign neuron_last = (out_cnt_reg == ncur_reg - DW'(1));

  // State, counters and registered address outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      ip_reg         <= '0;
      nprev_reg      <= '0;
      ncur_reg       <= '0;
      in_cnt_reg     <= '0;
      out_cnt_reg    <= '0;
      rd_base_reg    <= '0;
      wr_ptr_reg     <= '0;
      w_ptr_reg      <= '0;
      drain_cnt_reg  <= '0;
      last_layer_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      rd_addr_reg    <= '0;
      w_addr_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      ip_reg         <= ip_next;
      nprev_reg      <= nprev_next;
      ncur_reg       <= ncur_next;
      in_cnt_reg     <= in_cnt_next;
      out_cnt_reg    <= out_cnt_next;
      rd_base_reg    <= rd_base_next;
      wr_ptr_reg     <= wr_ptr_next;
      w_ptr_reg      <= w_ptr_next;
      drain_cnt_reg  <= drain_cnt_next;
      last_layer_reg <= last_layer_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      rd_addr_reg    <= rd_addr_next;
      w_addr_reg     <= w_addr_next;
    end
  end

  // Next-state logic: table walk, term issue and layer bookkeeping.
  always_comb begin
    state_next      = state_reg;
    ip_next         = ip_reg;
    nprev_next      = nprev_reg;
    ncur_next       = ncur_reg;
    in_cnt_next     = in_cnt_reg;
    out_cnt_next    = out_cnt_reg;
    rd_base_next    = rd_base_reg;
    wr_ptr_next     = wr_ptr_reg;
    w_ptr_next      = w_ptr_reg;
    drain_cnt_next  = drain_cnt_reg;
    last_layer_next = last_layer_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    rd_addr_next    = rd_addr_reg;
    w_addr_next     = w_addr_reg;
    iss_valid       = 1'b0;
    iss_first       = 1'b0;
    iss_last        = 1'b0;
    iss_waddr       = '0;

    unique case (state_reg)
      S_IDLE: begin
        busy_next = 1'b0;
        // done_reg is still high on the cycle the done pulse is visible;
        // a start coinciding with it belongs to the finished run.
        if (bus.start && !done_reg) begin
          state_next = S_LOAD;
          busy_next  = 1'b1;
        end
      end

      S_LOAD: begin
        if (bus.instr_data == '0) begin
          state_next = S_DONE;
        end else begin
          nprev_next      = bus.instr_data;
          rd_base_next    = '0;
          wr_ptr_next     = AW'(bus.instr_data);
          w_ptr_next      = '0;
          ip_next         = AW'(1);
          last_layer_next = 1'b0;
          state_next      = S_FETCH;
        end
      end

      S_FETCH: begin
        if (bus.instr_data == '0) begin
          state_next = S_DONE;
        end else begin
          ncur_next       = bus.instr_data;
          ip_next         = ip_reg + AW'(1);
          // Table index about to wrap: this is the final layer.
          last_layer_next = (ip_reg == '1);
          in_cnt_next     = '0;
          out_cnt_next    = '0;
          state_next      = S_RUN;
        end
      end

      S_RUN: begin
        rd_addr_next = rd_base_reg + AW'(in_cnt_reg);
        w_addr_next  = w_ptr_reg;
        w_ptr_next   = w_ptr_reg + AW'(1);
        iss_valid    = 1'b1;
        iss_first    = (in_cnt_reg == '0);
        iss_last     = term_last;
        if (term_last) begin
          iss_waddr    = wr_ptr_reg + AW'(out_cnt_reg);
          in_cnt_next  = '0;
          out_cnt_next = out_cnt_reg + DW'(1);
          if (neuron_last) begin
            // Layer complete: its outputs become the next layer's inputs.
            rd_base_next   = wr_ptr_reg;
            wr_ptr_next    = wr_ptr_reg + AW'(ncur_reg);
            nprev_next     = ncur_reg;
            drain_cnt_next = '0;
            state_next     = S_DRAIN;
          end
        end else begin
          in_cnt_next = in_cnt_reg + DW'(1);
        end
      end

      S_DRAIN: begin
        // Wait until the last write-back of the layer has landed.
        if (drain_cnt_reg == DCW'(LAT)) begin
          state_next = last_layer_reg ? S_DONE : S_FETCH;
        end else begin
          drain_cnt_next = drain_cnt_reg + DCW'(1);
        end
      end

      S_DONE: begin
        done_next  = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Issue stage of the delay lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_pipe_reg[0]    <= 1'b0;
      first_pipe_reg[0] <= 1'b0;
      wr_pipe_reg[0]    <= 1'b0;
      wa_pipe_reg[0]    <= '0;
    end else begin
      en_pipe_reg[0]    <= iss_valid;
      first_pipe_reg[0] <= iss_first;
      wr_pipe_reg[0]    <= iss_last;
      wa_pipe_reg[0]    <= iss_waddr;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= LAT; gi++) begin : g_mac_pipe
      // MAC enable/first advance one stage per cycle toward operand arrival.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          en_pipe_reg[gi]    <= 1'b0;
          first_pipe_reg[gi] <= 1'b0;
        end else begin
          en_pipe_reg[gi]    <= en_pipe_reg[gi-1];
          first_pipe_reg[gi] <= first_pipe_reg[gi-1];
        end
      end
    end

    for (gi = 1; gi <= LAT + 1; gi++) begin : g_wr_pipe
      // Write-back strobe and address trail the MAC by one extra stage.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_pipe_reg[gi] <= 1'b0;
          wa_pipe_reg[gi] <= '0;
        end else begin
          wr_pipe_reg[gi] <= wr_pipe_reg[gi-1];
          wa_pipe_reg[gi] <= wa_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign bus.busy           = busy_reg;
  assign bus.done           = done_reg;
  assign bus.instr_addr     = (state_reg == S_IDLE || state_reg == S_LOAD) ? '0 : ip_reg;
  assign bus.neuro_rd_addr  = rd_addr_reg;
  assign bus.weight_rd_addr = w_addr_reg;
  assign bus.mac_en         = en_pipe_reg[LAT];
  assign bus.mac_first      = first_pipe_reg[LAT];
  assign bus.neuro_wr_en    = wr_pipe_reg[LAT+1];
  assign bus.neuro_wr_addr  = wa_pipe_reg[LAT+1];

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Bench for the layer sequencer: a table-driven network model predicts the full
// cycle-by-cycle output trace, which is compared against the captured DUT trace.
module tb_mac_layer_sequencer;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int LAT  = 2;
  localparam int MAXC = 640;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mac_layer_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  mac_layer_sequencer #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] imem [0:(1<<AW)-1];
  assign bus.instr_data = imem[bus.instr_addr];

  always #5 clk = ~clk;

  int n_pass;
  int n_total;
  int tbl[$];

  logic          start_at [0:MAXC-1];
  logic          e_busy   [0:MAXC-1];
  logic          e_done   [0:MAXC-1];
  logic          e_en     [0:MAXC-1];
  logic          e_first  [0:MAXC-1];
  logic          e_wen    [0:MAXC-1];
  logic          e_iss    [0:MAXC-1];
  logic [AW-1:0] e_wraddr [0:MAXC-1];
  logic [AW-1:0] e_raddr  [0:MAXC-1];
  logic [AW-1:0] e_waddr  [0:MAXC-1];
  logic          o_busy   [0:MAXC-1];
  logic          o_done   [0:MAXC-1];
  logic          o_en     [0:MAXC-1];
  logic          o_first  [0:MAXC-1];
  logic          o_wen    [0:MAXC-1];
  logic [AW-1:0] o_wraddr [0:MAXC-1];
  logic [AW-1:0] o_raddr  [0:MAXC-1];
  logic [AW-1:0] o_waddr  [0:MAXC-1];

  task automatic clear_model();
    for (int c = 0; c < MAXC; c++) begin
      start_at[c] = 1'b0; e_busy[c] = 1'b0; e_done[c] = 1'b0; e_en[c] = 1'b0;
      e_first[c] = 1'b0; e_wen[c] = 1'b0; e_iss[c] = 1'b0;
      e_wraddr[c] = '0; e_raddr[c] = '0; e_waddr[c] = '0;
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < (1 << AW); i++) imem[i] = '0;
    for (int i = 0; i < tbl.size(); i++) imem[i] = DW'(tbl[i]);
  endtask

  // Network-level prediction for a run whose start is accepted at edge off:
  // layers are walked from the table, every MAC term is listed with its
  // addresses, then placed on the timeline using the fixed LAT offsets.
  task automatic model_run(input int off, output int done_c);
    int nprev, ncur, rd_base, wr_ptr, w_ptr, c, k, t;
    done_c = -1;
    if (tbl[0] == 0) begin
      done_c = off + 2;
    end else begin
      nprev = tbl[0]; rd_base = 0; wr_ptr = tbl[0]; w_ptr = 0;
      c = off + 1; k = 1;
      while (done_c < 0) begin
        ncur = (k < tbl.size()) ? tbl[k] : 0;
        if (ncur == 0) begin
          done_c = c + 2;
        end else begin
          t = c + 2;
          for (int n = 0; n < ncur; n++) begin
            for (int i = 0; i < nprev; i++) begin
              e_iss[t] = 1'b1;
              e_raddr[t] = AW'((rd_base + i) % (1 << AW));
              e_waddr[t] = AW'(w_ptr % (1 << AW));
              e_en[t+LAT] = 1'b1;
              e_first[t+LAT] = (i == 0);
              if (i == nprev - 1) begin
                e_wen[t+LAT+1] = 1'b1;
                e_wraddr[t+LAT+1] = AW'((wr_ptr + n) % (1 << AW));
              end
              w_ptr++;
              t++;
            end
          end
          c = t + LAT;
          rd_base = wr_ptr; wr_ptr = wr_ptr + ncur; nprev = ncur; k++;
        end
      end
    end
    for (int i = off; i <= done_c; i++) e_busy[i] = 1'b1;
    e_done[done_c] = 1'b1;
  endtask

  // Drives start per cycle and records the outputs mid-cycle; call after a negedge.
  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      bus.start = start_at[c];
      @(posedge clk);
      @(negedge clk);
      o_busy[c] = bus.busy; o_done[c] = bus.done; o_en[c] = bus.mac_en;
      o_first[c] = bus.mac_first; o_wen[c] = bus.neuro_wr_en;
      o_wraddr[c] = bus.neuro_wr_addr; o_raddr[c] = bus.neuro_rd_addr;
      o_waddr[c] = bus.weight_rd_addr;
    end
    bus.start = 1'b0;
  endtask

  function automatic logic [28:0] exp_word(input int c);
    return {e_busy[c], e_done[c], e_en[c], e_first[c], e_wen[c],
            e_wraddr[c], e_raddr[c], e_waddr[c]};
  endfunction

  // Addresses are only defined on cycles where the model expects them.
  function automatic logic [28:0] obs_word(input int c);
    return {o_busy[c], o_done[c], o_en[c], o_first[c], o_wen[c],
            e_wen[c] ? o_wraddr[c] : 8'h00,
            e_iss[c] ? o_raddr[c] : 8'h00,
            e_iss[c] ? o_waddr[c] : 8'h00};
  endfunction

  function automatic logic [44:0] outs_now();
    return {bus.busy, bus.done, bus.mac_en, bus.mac_first, bus.neuro_wr_en,
            bus.neuro_wr_addr, bus.neuro_rd_addr, bus.weight_rd_addr, bus.instr_addr, 8'h00};
  endfunction

  task automatic test_reset();
    tbl.delete(); tbl.push_back(2); tbl.push_back(3); tbl.push_back(0);
    load_table();
    bus.start = 1'b0;
    #1 reset = 1'b0;
    #1;
    n_total++;
    if (outs_now() !== 45'h0) $display("FAIL reset_async: outputs %h, required 0", outs_now());
    else n_pass++;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    n_total++;
    if (outs_now() !== 45'h0) $display("FAIL reset_idle: outputs %h, required 0", outs_now());
    else n_pass++;
    $display("reset: outputs %h", outs_now());
  endtask

  task automatic test_single_layer();
    int dc;
    tbl.delete(); tbl.push_back(2); tbl.push_back(3); tbl.push_back(0);
    load_table(); clear_model();
    start_at[0] = 1'b1;
    model_run(0, dc);
    capture(dc + 4);
    for (int c = 0; c < dc + 4; c++) begin
      n_total++;
      if (obs_word(c) !== exp_word(c))
        $display("FAIL single_layer cycle %0d: got %h, required %h", c, obs_word(c), exp_word(c));
      else n_pass++;
    end
    $display("single_layer [2,3,0]: done expected at cycle %0d", dc);
  endtask

  task automatic test_two_layer();
    int dc, last_c;
    tbl.delete(); tbl.push_back(2); tbl.push_back(2); tbl.push_back(1); tbl.push_back(0);
    load_table(); clear_model();
    start_at[0] = 1'b1;
    model_run(0, dc);
    capture(dc + 4);
    for (int c = 0; c < dc + 4; c++) begin
      n_total++;
      if (obs_word(c) !== exp_word(c))
        $display("FAIL two_layer cycle %0d: got %h, required %h", c, obs_word(c), exp_word(c));
      else n_pass++;
    end
    last_c = -1;
    for (int c = 0; c < dc + 4; c++) if (o_wen[c] === 1'b1) last_c = c;
    n_total++;
    if (last_c < 0 || o_wraddr[last_c] !== 8'd4)
      $display("FAIL two_layer_last_write: cycle %0d, required address 4", last_c);
    else n_pass++;
    $display("two_layer [2,2,1,0]: last write at cycle %0d", last_c);
  endtask

  task automatic test_empty();
    int dc;
    tbl.delete(); tbl.push_back(0);
    load_table(); clear_model();
    start_at[0] = 1'b1;
    model_run(0, dc);
    capture(8);
    for (int c = 0; c < 8; c++) begin
      n_total++;
      if (obs_word(c) !== exp_word(c))
        $display("FAIL empty cycle %0d: got %h, required %h", c, obs_word(c), exp_word(c));
      else n_pass++;
    end
    $display("empty [0]: done expected at cycle %0d", dc);
  endtask

  task automatic test_reset_mid_run();
    int dc;
    tbl.delete(); tbl.push_back(2); tbl.push_back(3); tbl.push_back(0);
    load_table(); clear_model();
    start_at[0] = 1'b1;
    model_run(0, dc);
    capture(6);
    for (int c = 0; c < 6; c++) begin
      n_total++;
      if (obs_word(c) !== exp_word(c))
        $display("FAIL mid_run_prefix cycle %0d: got %h, required %h", c, obs_word(c), exp_word(c));
      else n_pass++;
    end
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (outs_now() !== 45'h0) $display("FAIL mid_run_reset: outputs %h, required 0", outs_now());
    else n_pass++;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    capture(dc + 4);
    for (int c = 0; c < dc + 4; c++) begin
      n_total++;
      if (obs_word(c) !== exp_word(c))
        $display("FAIL mid_run_rerun cycle %0d: got %h, required %h", c, obs_word(c), exp_word(c));
      else n_pass++;
    end
    $display("reset_mid_run: rerun of [2,3,0] captured");
  endtask

  task automatic test_start_ignored();
    int dc1, dc2;
    tbl.delete(); tbl.push_back(2); tbl.push_back(3); tbl.push_back(0);
    load_table(); clear_model();
    model_run(0, dc1);
    model_run(dc1 + 2, dc2);
    start_at[0] = 1'b1; start_at[5] = 1'b1; start_at[9] = 1'b1; start_at[10] = 1'b1;
    start_at[12] = 1'b1; start_at[13] = 1'b1;
    start_at[dc1 + 1] = 1'b1;
    start_at[dc1 + 2] = 1'b1;
    capture(dc2 + 4);
    for (int c = 0; c < dc2 + 4; c++) begin
      n_total++;
      if (obs_word(c) !== exp_word(c))
        $display("FAIL start_ignored cycle %0d: got %h, required %h", c, obs_word(c), exp_word(c));
      else n_pass++;
    end
    $display("start_ignored: second run accepted at edge %0d", dc1 + 2);
  endtask

  task automatic test_wrap();
    int dc, last_c;
    tbl.delete(); tbl.push_back(16); tbl.push_back(17); tbl.push_back(0);
    load_table(); clear_model();
    start_at[0] = 1'b1;
    model_run(0, dc);
    capture(dc + 4);
    for (int c = 0; c < dc + 4; c++) begin
      n_total++;
      if (obs_word(c) !== exp_word(c))
        $display("FAIL wrap cycle %0d: got %h, required %h", c, obs_word(c), exp_word(c));
      else n_pass++;
    end
    last_c = -1;
    for (int c = 0; c < dc + 4; c++) if (o_wen[c] === 1'b1) last_c = c;
    n_total++;
    if (last_c < 0 || o_wraddr[last_c] !== 8'd32)
      $display("FAIL wrap_last_write: cycle %0d, required address 32", last_c);
    else n_pass++;
    $display("wrap [16,17,0]: last write at cycle %0d", last_c);
  endtask

  task automatic test_random();
    int dc, d, nl, errs;
    for (int r = 0; r < 8; r++) begin
      tbl.delete();
      tbl.push_back(int'($urandom_range(1, 4)));
      nl = int'($urandom_range(0, 3));
      for (int l = 0; l < nl; l++) tbl.push_back(int'($urandom_range(1, 4)));
      tbl.push_back(0);
      load_table(); clear_model();
      d = int'($urandom_range(0, 3));
      start_at[d] = 1'b1;
      model_run(d, dc);
      for (int p = 0; p < 3; p++) start_at[int'($urandom_range(d + 1, dc + 1))] = 1'b1;
      capture(dc + 5);
      errs = 0;
      for (int c = 0; c < dc + 5; c++) begin
        n_total++;
        if (obs_word(c) !== exp_word(c)) begin
          errs++;
          $display("FAIL random%0d cycle %0d: got %h, required %h", r, c, obs_word(c), exp_word(c));
        end else n_pass++;
      end
      $display("random%0d: %0d layers, start at %0d, done at %0d, %0d errors", r, nl, d, dc, errs);
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    bus.start = 1'b0;
    test_reset();
    test_single_layer();
    test_two_layer();
    test_empty();
    test_reset_mid_run();
    test_start_ignored();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
